// File: rtl/nim_turn_controller.sv
// nim_turn_controller: sequences a Nim match (pile, turn, move validation) and drives score-board controls
module nim_turn_controller #(
  parameter int PILE_INIT = 21,
  parameter int MAX_TAKE  = 3,
  parameter int WIN_SCORE = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       take_valid,
  input  logic [1:0] take_count,
  output logic [4:0] pile,
  output logic       turn,
  output logic       newGame,
  output logic       lpScoreUp,
  output logic       rpScoreUp,
  output logic       lWinner,
  output logic       rWinner,
  output logic       move_err
);
  localparam int SW = $clog2(WIN_SCORE + 1);
  typedef enum logic [1:0] {IDLE, PLAY, ROUND_END, MATCH_END} state_t;
  state_t         state_q, state_d;
  logic [4:0]     pile_q, pile_d, new_pile;
  logic           turn_q, turn_d;
  logic [SW-1:0]  lsc_q, lsc_d, rsc_q, rsc_d, mover_sc;
  logic           new_game_q, new_game_d, lp_up_q, lp_up_d, rp_up_q, rp_up_d;
  logic           lw_q, lw_d, rw_q, rw_d, err_q, err_d;
  logic           legal, win;
  always_comb begin
    new_pile   = pile_q - {3'd0, take_count};
    legal      = take_count != 2'd0 && 32'(take_count) <= MAX_TAKE && {3'd0, take_count} <= pile_q;
    mover_sc   = (turn_q ? rsc_q : lsc_q) + SW'(1);
    win        = mover_sc == SW'(WIN_SCORE);
    state_d    = state_q;
    pile_d     = pile_q;
    turn_d     = turn_q;
    lsc_d      = lsc_q;
    rsc_d      = rsc_q;
    lw_d       = lw_q;
    rw_d       = rw_q;
    new_game_d = 1'b0;
    lp_up_d    = 1'b0;
    rp_up_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE, MATCH_END: if (start) begin
        new_game_d = 1'b1;
        lsc_d      = '0;
        rsc_d      = '0;
        lw_d       = 1'b0;
        rw_d       = 1'b0;
        pile_d     = 5'(PILE_INIT);
        turn_d     = 1'b0;
        state_d    = PLAY;
      end
      PLAY: if (take_valid) begin
        err_d  = !legal;
        pile_d = legal ? new_pile : pile_q;
        if (legal && new_pile != 5'd0) turn_d = !turn_q;
        if (legal && new_pile == 5'd0) begin
          lsc_d   = turn_q ? lsc_q : mover_sc;
          rsc_d   = turn_q ? mover_sc : rsc_q;
          lp_up_d = !turn_q;
          rp_up_d = turn_q;
          lw_d    = !turn_q && win;
          rw_d    = turn_q && win;
          state_d = win ? MATCH_END : ROUND_END;
        end
      end
      ROUND_END: if (start) begin
        pile_d  = 5'(PILE_INIT);
        turn_d  = !turn_q;
        state_d = PLAY;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pile_q     <= 5'(PILE_INIT);
      turn_q     <= 1'b0;
      lsc_q      <= '0;
      rsc_q      <= '0;
      new_game_q <= 1'b0;
      lp_up_q    <= 1'b0;
      rp_up_q    <= 1'b0;
      lw_q       <= 1'b0;
      rw_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pile_q     <= pile_d;
      turn_q     <= turn_d;
      lsc_q      <= lsc_d;
      rsc_q      <= rsc_d;
      new_game_q <= new_game_d;
      lp_up_q    <= lp_up_d;
      rp_up_q    <= rp_up_d;
      lw_q       <= lw_d;
      rw_q       <= rw_d;
      err_q      <= err_d;
    end
  end
  assign pile      = pile_q;
  assign turn      = turn_q;
  assign newGame   = new_game_q;
  assign lpScoreUp = lp_up_q;
  assign rpScoreUp = rp_up_q;
  assign lWinner   = lw_q;
  assign rWinner   = rw_q;
  assign move_err  = err_q;
endmodule

// File: doc/nim_turn_controller.md
Name:
nim_turn_controller

Overview:
Sequences one Game of Nim match between the left and right players and drives the score-board block's control inputs: newGame, the per-player score-up pulses, and the winner flags. It holds the stone pile and the turn pointer, validates each submitted move, and detects round and match end. It sits between the debounced button/switch front end and the score-board / seven-segment path.

Parameters:
PILE_INIT, 21, stones placed on the pile at the start of every round (1..31)
MAX_TAKE, 3, maximum stones removable per move (1..3)
WIN_SCORE, 5, round wins needed to win the match (1..9)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; returns block to IDLE
start  in  1  single-cycle pulse: begin round / begin new match
take_valid  in  1  single-cycle pulse: current player submits a move
take_count  in  2  stones requested by the move, sampled with take_valid
pile  out  5  stones remaining, registered
turn  out  1  player to move: 0 = left, 1 = right, registered
newGame  out  1  one-cycle pulse: clear score board
lpScoreUp  out  1  one-cycle pulse: left player won a round
rpScoreUp  out  1  one-cycle pulse: right player won a round
lWinner  out  1  level: left player won the match
rWinner  out  1  level: right player won the match
move_err  out  1  one-cycle pulse: illegal move rejected

Behaviour:
- All outputs registered; every input event is sampled at rising edge N, and its effects are visible after edge N. No combinational input-to-output paths.
- Reset (async): state=IDLE, pile=PILE_INIT, turn=0, internal scores lsc=rsc=0, all pulses 0, lWinner=rWinner=0.
- States: IDLE, PLAY, ROUND_END, MATCH_END.
- IDLE / MATCH_END + start:
  - newGame=1 for one cycle; lsc=rsc=0; lWinner=rWinner=0.
  - pile=PILE_INIT, turn=0, go to PLAY.
  - take_valid is ignored in both states.
- PLAY + take_valid, legal when 1 <= take_count <= MAX_TAKE and take_count <= pile:
  - pile -= take_count.
  - If the new pile is nonzero, turn toggles.
  - If the new pile is 0, the mover wins the round (normal play; last stone wins):
    - turn is unchanged.
    - The mover's ScoreUp pulses for one cycle and its internal score increments.
    - If the new score == WIN_SCORE: that player's Winner goes to 1, go to MATCH_END.
    - Otherwise go to ROUND_END.
- PLAY + take_valid, illegal (take_count=0, > MAX_TAKE, or > pile): move_err=1 for one cycle; pile, turn and state unchanged.
- PLAY + start: ignored, no abort. start and take_valid in the same cycle: the move is processed and start is dropped.
- ROUND_END + start:
  - pile=PILE_INIT.
  - turn = loser of the previous round (inverted winner).
  - Go to PLAY. No newGame pulse.
  - take_valid is ignored in ROUND_END; start wins if both occur in the same cycle.
- Winner flags hold until the next new-match start or reset. At most one is ever 1.
- Internal scores are clog2(WIN_SCORE+1) bits, never exceed WIN_SCORE, and never wrap.
- Reset asserted mid-round or during a pulse: pulses are cut immediately and all state returns to reset values. No pulse is emitted on reset release.

Test Plan:
- Reset, then start -> newGame high exactly 1 cycle, pile=21, turn=0, state PLAY; no ScoreUp or Winner.
- Legal sequence L3,R3,L3,R3,L3,R3,L3 (21 stones) -> pile 18,15,...,0; after the last move lpScoreUp pulses 1 cycle, turn stays 0, ROUND_END. Next start -> pile=21, turn=1, no newGame.
- Illegal moves with pile=2: take_count=3, then take_count=0 -> move_err pulses each time; pile=2 and turn unchanged. take_count=2 then accepted -> pile=0, round win.
- Right player wins 5 rounds (WIN_SCORE=5) -> 5 rpScoreUp pulses, rWinner=1 latched, lWinner=0. Further take_valid is ignored. start -> newGame pulse, rWinner=0, pile=21, turn=0.
- start and take_valid (count 2) in the same cycle during PLAY with pile=21 -> pile=19, turn toggles, no restart. Same pair in ROUND_END -> new round starts, move dropped.
- Assert reset while pile=7 and turn=1 mid-round -> immediately pile=21, turn=0, IDLE, all outputs 0. start required to resume.
